// File: rtl/bumpy_motion_fsm.sv
// Bumpy ball motion/collision engine: per-frame gravity, bounce, key motion,
// tile collision decisions and level/lives bookkeeping for the map controller.
module bumpy_motion_fsm #(
  parameter int BUMPY_SIZE   = 32,
  parameter int GRAVITY      = 6,
  parameter int BOUNCE_V     = 96,
  parameter int HSPEED       = 32,
  parameter int VMAX         = 255,
  parameter int START_X      = 64,
  parameter int START_Y      = 320,
  parameter int LIVES        = 3,
  parameter int NUM_LVLS     = 2,
  parameter int DEATH_FRAMES = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startOfFrame,
  input  logic             key_left,
  input  logic             key_right,
  input  logic [3:0][2:0]  area,
  output logic [10:0]      bumpy_x,
  output logic [10:0]      bumpy_y,
  output logic [2:0]       lvl,
  output logic             next_lvl,
  output logic [1:0]       lives,
  output logic             dying,
  output logic             game_over,
  output logic             win
);
  localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_DYING = 2'd2, S_OVER = 2'd3;
  localparam logic [2:0] T_FREE = 3'd0, T_REGU = 3'd1, T_GATE = 3'd2, T_DEATH = 3'd3,
                         T_WALL = 3'd4, T_SPIKE = 3'd5, T_BRAKE = 3'd6;
  localparam int CW = $clog2(DEATH_FRAMES + 1);
  localparam logic [14:0] START_PX = 15'(START_X * 16);
  localparam logic [14:0] START_PY = 15'(START_Y * 16);
  localparam logic signed [16:0] XMAX = 17'((640 - BUMPY_SIZE) * 16);
  localparam logic signed [16:0] YMAX = 17'((448 - BUMPY_SIZE) * 16);
  localparam logic signed [10:0] VMAX_S = 11'(VMAX);

  logic [1:0]        state;
  logic [14:0]       pos_x, pos_y;
  logic signed [9:0] vx, vy;
  logic [CW-1:0]     cnt;

  logic [10:0]        y_px;
  logic [11:0]        y_bot, y_bnd, bnd_r;
  logic               contact, hazard, gate;
  logic signed [10:0] vy_g;
  logic signed [9:0]  vy_n, vx_n;
  logic signed [16:0] py, px, cur_x, lim_l, lim_r;

  assign y_px    = pos_y[14:4];
  assign y_bot   = {1'b0, y_px} + 12'(BUMPY_SIZE);
  assign y_bnd   = {({1'b0, y_px[10:6]} + 6'd1), 6'd0};
  assign contact = (y_bot >= y_bnd);
  assign hazard  = contact && (area[3] == T_SPIKE || area[3] == T_DEATH);
  assign gate    = contact && (area[3] == T_GATE);

  // vertical: gravity, floor bounce, ceiling stop
  always_comb begin
    vy_g = {vy[9], vy} + 11'(GRAVITY);
    if (vy_g > VMAX_S) vy_g = VMAX_S;
    vy_n = vy_g[9:0];
    py   = $signed({2'b00, pos_y}) + {{6{vy_g[10]}}, vy_g};
    if (vy_g > 11'sd0 && (area[3] == T_REGU || area[3] == T_BRAKE) && contact) begin
      py   = {1'b0, y_bnd - 12'(BUMPY_SIZE), 4'd0};
      vy_n = 10'(-BOUNCE_V);
    end else if (vy_g < 11'sd0 && area[1] != T_FREE && y_px[5:0] == 6'd0) begin
      py   = $signed({2'b00, pos_y});
      vy_n = 10'sd0;
    end
    if (py < 17'sd0) py = 17'sd0;
    else if (py > YMAX) py = YMAX;
  end

  // horizontal: key speed, brake, wall stop at the current tile edge
  always_comb begin
    vx_n = 10'sd0;
    if (key_right && !key_left) vx_n = 10'(HSPEED);
    else if (key_left && !key_right) vx_n = 10'(-HSPEED);
    if (area[3] == T_BRAKE && contact) vx_n = 10'sd0;
    cur_x = $signed({2'b00, pos_x});
    bnd_r = {1'b0, pos_x[14:10], 6'd0} + 12'd64;
    lim_r = {1'b0, bnd_r - 12'(BUMPY_SIZE), 4'd0};
    lim_l = {2'b00, pos_x[14:10], 10'd0};
    px    = cur_x + {{7{vx_n[9]}}, vx_n};
    if (vx_n > 10'sd0 && (area[2] == T_WALL || area[2] == T_REGU) && px > lim_r)
      px = (lim_r > cur_x) ? lim_r : cur_x;
    if (vx_n < 10'sd0 && (area[0] == T_WALL || area[0] == T_REGU) && px < lim_l)
      px = (lim_l < cur_x) ? lim_l : cur_x;
    if (px < 17'sd0) px = 17'sd0;
    else if (px > XMAX) px = XMAX;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pos_x    <= START_PX;
      pos_y    <= START_PY;
      vx       <= '0;
      vy       <= '0;
      lvl      <= '0;
      lives    <= 2'(LIVES);
      next_lvl <= 1'b0;
      win      <= 1'b0;
      cnt      <= '0;
    end else begin
      next_lvl <= 1'b0;
      if (startOfFrame) begin
        case (state)
          S_IDLE: state <= S_PLAY;
          S_PLAY: begin
            if (hazard) begin
              lives <= lives - 2'd1;
              if (lives == 2'd1) state <= S_OVER;
              else begin
                state <= S_DYING;
                cnt   <= '0;
              end
            end else if (gate) begin
              if (lvl == 3'(NUM_LVLS - 1)) begin
                win   <= 1'b1;
                state <= S_OVER;
              end else begin
                lvl      <= lvl + 3'd1;
                next_lvl <= 1'b1;
                pos_x    <= START_PX;
                pos_y    <= START_PY;
                vx       <= '0;
                vy       <= '0;
              end
            end else begin
              pos_x <= px[14:0];
              pos_y <= py[14:0];
              vx    <= vx_n;
              vy    <= vy_n;
            end
          end
          S_DYING: begin
            if (cnt == CW'(DEATH_FRAMES - 1)) begin
              state <= S_PLAY;
              pos_x <= START_PX;
              pos_y <= START_PY;
              vx    <= '0;
              vy    <= '0;
            end else cnt <= cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bumpy_x   = pos_x[14:4];
  assign bumpy_y   = pos_y[14:4];
  assign dying     = (state == S_DYING);
  assign game_over = (state == S_OVER);
endmodule

// File: tb/tb_bumpy_motion_fsm.sv
// Directed table-driven bench for bumpy_motion_fsm: each record runs N frames
// with fixed inputs, then compares position, lives, level and flags.
module tb_bumpy_motion_fsm;
  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            sof = 1'b0;
  logic            key_left = 1'b0, key_right = 1'b0;
  logic [3:0][2:0] area = '0;
  logic [10:0]     bumpy_x, bumpy_y;
  logic [2:0]      lvl;
  logic            next_lvl;
  logic [1:0]      lives;
  logic            dying, game_over, win;

  bumpy_motion_fsm dut (
    .clk(clk), .reset(reset), .startOfFrame(sof),
    .key_left(key_left), .key_right(key_right), .area(area),
    .bumpy_x(bumpy_x), .bumpy_y(bumpy_y), .lvl(lvl), .next_lvl(next_lvl),
    .lives(lives), .dying(dying), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit kl; bit kr; logic [11:0] ar; int nfr;
    int x; int y; int lv; int lvl; int dy; int ov; int wn; int pl;
  } vec_t;
  vec_t vecs[$];

  int ntests = 0, nfail = 0, pulses = 0;

  function automatic void chk(string name, int idx, int act, int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endfunction

  function automatic void add(bit rst, bit kl, bit kr, logic [11:0] ar, int nfr,
                              int x, int y, int lv, int l, int dy, int ov, int wn, int pl);
    vec_t v;
    v.rst = rst; v.kl = kl; v.kr = kr; v.ar = ar; v.nfr = nfr;
    v.x = x; v.y = y; v.lv = lv; v.lvl = l; v.dy = dy; v.ov = ov; v.wn = wn; v.pl = pl;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; sof = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  // one frame = SOF pulse then three idle cycles; next_lvl sampled each cycle
  task automatic frame();
    @(negedge clk); sof = 1'b1;
    @(negedge clk); sof = 1'b0;
    if (next_lvl) pulses++;
    repeat (2) begin
      @(negedge clk);
      if (next_lvl) pulses++;
    end
  endtask

  initial begin
    // tile codes at area[3]: REGU 200 GATE 400 SPIKE A00 BRAKE C00; WALL at area[2]: 100
    // free fall then floor bounce
    add(1,0,0,12'h000, 0, 64,320,3,0,0,0,0,0);
    add(0,0,0,12'h000, 1, 64,320,3,0,0,0,0,0);
    add(0,0,0,12'h000,10, 64,340,3,0,0,0,0,0);
    add(0,0,0,12'h200, 3, 64,354,3,0,0,0,0,0);
    add(0,0,0,12'h200, 1, 64,352,3,0,0,0,0,0);
    add(0,0,0,12'h200, 1, 64,346,3,0,0,0,0,0);
    // right wall stop and floor clamp
    add(1,0,1,12'h100, 1, 64,320,3,0,0,0,0,0);
    add(0,0,1,12'h100,14, 92,359,3,0,0,0,0,0);
    add(0,0,1,12'h100, 2, 96,371,3,0,0,0,0,0);
    add(0,0,1,12'h100, 4, 96,398,3,0,0,0,0,0);
    add(0,0,1,12'h100, 4, 96,416,3,0,0,0,0,0);
    // left screen clamp
    add(1,1,0,12'h000, 1, 64,320,3,0,0,0,0,0);
    add(0,1,0,12'h000,33,  0,416,3,0,0,0,0,0);
    // brake tile: bounce and horizontal stop
    add(1,0,1,12'hC00, 1, 64,320,3,0,0,0,0,0);
    add(0,0,1,12'hC00,13, 90,354,3,0,0,0,0,0);
    add(0,0,1,12'hC00, 1, 90,352,3,0,0,0,0,0);
    add(0,0,1,12'hC00, 1, 90,346,3,0,0,0,0,0);
    // spike deaths down to game over
    add(1,0,0,12'hA00, 1, 64,320,3,0,0,0,0,0);
    add(0,0,0,12'hA00,13, 64,354,3,0,0,0,0,0);
    add(0,0,0,12'hA00, 1, 64,354,2,0,1,0,0,0);
    add(0,0,0,12'hA00,59, 64,354,2,0,1,0,0,0);
    add(0,0,0,12'hA00, 1, 64,320,2,0,0,0,0,0);
    add(0,0,0,12'hA00,14, 64,354,1,0,1,0,0,0);
    add(0,0,0,12'hA00,60, 64,320,1,0,0,0,0,0);
    add(0,0,0,12'hA00,14, 64,354,0,0,0,1,0,0);
    add(0,0,1,12'h000, 5, 64,354,0,0,0,1,0,0);
    // gates: level up, then win on the last level
    add(1,0,0,12'h400, 1, 64,320,3,0,0,0,0,0);
    add(0,0,0,12'h400,13, 64,354,3,0,0,0,0,0);
    add(0,0,0,12'h400, 1, 64,320,3,1,0,0,0,1);
    add(0,0,0,12'h400,14, 64,354,3,1,0,1,1,0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      key_left = vecs[i].kl; key_right = vecs[i].kr; area = vecs[i].ar;
      pulses = 0;
      repeat (vecs[i].nfr) frame();
      @(negedge clk);
      chk("bumpy_x",   i, int'(bumpy_x),   vecs[i].x);
      chk("bumpy_y",   i, int'(bumpy_y),   vecs[i].y);
      chk("lives",     i, int'(lives),     vecs[i].lv);
      chk("lvl",       i, int'(lvl),       vecs[i].lvl);
      chk("dying",     i, int'(dying),     vecs[i].dy);
      chk("game_over", i, int'(game_over), vecs[i].ov);
      chk("win",       i, int'(win),       vecs[i].wn);
      chk("pulses",    i, pulses,          vecs[i].pl);
    end

    // next_lvl timing: high in the cycle right after the SOF edge, then low
    do_reset();
    key_left = 0; key_right = 0; area = 12'h400;
    repeat (14) frame();
    @(negedge clk); sof = 1'b1;
    @(negedge clk); sof = 1'b0;
    chk("next_lvl_hi", 100, int'(next_lvl), 1);
    chk("lvl_up",      100, int'(lvl),      1);
    @(negedge clk);
    chk("next_lvl_lo", 100, int'(next_lvl), 0);

    // reset in the middle of the death freeze
    do_reset();
    area = 12'hA00;
    repeat (14) frame();
    repeat (30) frame();
    @(negedge clk);
    chk("dying_mid", 101, int'(dying), 1);
    chk("lives_mid", 101, int'(lives), 2);
    do_reset();
    chk("rst_x",      101, int'(bumpy_x),   64);
    chk("rst_y",      101, int'(bumpy_y),   320);
    chk("rst_lives",  101, int'(lives),     3);
    chk("rst_dying",  101, int'(dying),     0);
    chk("rst_lvl",    101, int'(lvl),       0);
    chk("rst_over",   101, int'(game_over), 0);
    chk("rst_nextlv", 101, int'(next_lvl),  0);
    // after reset the FSM must sit in IDLE: first frame causes no motion
    frame();
    @(negedge clk);
    chk("idle_y", 101, int'(bumpy_y), 320);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
